decoder3to8_pulse: RTL and testbench

- Converse of the team's 8-to-3 active-low priority encoder.
- Accepts a 4-bit code {valid, idx[2:0]} (same format the encoder emits) over a valid/ready handshake.
- Drives the selected active-low line w_n[idx+1] low for a timed pulse, then enforces an idle gap before accepting the next code.
- Used to replay encoded requests back onto a one-hot active-low line bank; a loopback through the encoder must reproduce the code.

---
 rtl/decoder3to8_pulse_pkg.sv | 18 +
 rtl/decoder3to8_pulse_if.sv | 21 ++
 rtl/decoder3to8_pulse_line_onehot_n.sv | 13 +
 rtl/decoder3to8_pulse.sv | 106 ++++++++++
 tb/tb_decoder3to8_pulse.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder3to8_pulse_pkg.sv
// Shared constants for the 3-to-8 active-low pulse decoder: code fields, FSM encoding, line levels.
package decoder3to8_pulse_pkg;

  typedef logic [3:0] code_t;
  typedef logic [2:0] idx_t;
  typedef logic [8:1] line_t;

  localparam int unsigned CODE_VALID_BIT = 3;
  localparam int unsigned CODE_IDX_MSB   = 2;
  localparam int unsigned CODE_IDX_LSB   = 0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam line_t LINE_IDLE = 8'hFF;

endpackage

// File: rtl/decoder3to8_pulse_if.sv
// Code handshake between an upstream producer and the pulse decoder.
interface decoder3to8_pulse_if;
  import decoder3to8_pulse_pkg::*;

  logic  in_valid;
  logic  in_ready;
  code_t code;

  modport master (
    output in_valid,
    output code,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  code,
    output in_ready
  );

endinterface

// File: rtl/decoder3to8_pulse_line_onehot_n.sv
// Combinational 3-bit index to 8-line active-low one-hot decode (idx 0 -> line_n[1]).
module line_onehot_n
  import decoder3to8_pulse_pkg::*;
(
  input  idx_t  idx,
  output line_t line_n
);

  always_comb begin
    line_n = ~(line_t'(1) << idx);
  end

endmodule

// File: rtl/decoder3to8_pulse.sv
// Replays a {valid, idx} code as a timed active-low pulse on one line, then holds an idle gap.
module decoder3to8_pulse
  import decoder3to8_pulse_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  decoder3to8_pulse_if.slave  bus,
  output line_t               w_n,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W-1:0] PulseLoad = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  code_t            code_q, code_d;
  line_t            w_n_d;
  line_t            line_sel_n;
  logic             busy_d;
  logic             done_d;
  logic             accept;

  assign bus.in_ready = (state_q == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign code_d       = accept ? bus.code : code_q;

  line_onehot_n u_line (
    .idx    (code_d[CODE_IDX_MSB:CODE_IDX_LSB]),
    .line_n (line_sel_n)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_n_d   = w_n;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Null codes never touch w_n, so an unknown index cannot leak onto the lines.
          if (code_d[CODE_VALID_BIT]) begin
            state_d = PULSE;
            w_n_d   = line_sel_n;
            cnt_d   = PulseLoad;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          w_n_d = LINE_IDLE;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GapLoad;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        w_n_d   = LINE_IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Asynchronous reset releases a held line immediately, without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      w_n     <= LINE_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      w_n     <= w_n_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_decoder3to8_pulse.sv
// Bench for decoder3to8_pulse: cycle-indexed reference model plus directed literal checks.
module tb_decoder3to8_pulse;
  import decoder3to8_pulse_pkg::*;

  localparam int P = 4;
  localparam int G = 2;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  always #5 clk = ~clk;

  decoder3to8_pulse_if bus ();
  decoder3to8_pulse_if bus2 ();

  line_t w_n, w_n2;
  logic  busy, done, busy2, done2;

  decoder3to8_pulse #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .w_n  (w_n),
    .busy (busy),
    .done (done)
  );

  decoder3to8_pulse #(.PULSE_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut2 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus2),
    .w_n  (w_n2),
    .busy (busy2),
    .done (done2)
  );

  int   nchecks = 0;
  int   nerrors = 0;
  int   now, free_from, done_cyc, lo, hi, pidx, last_acc;
  logic accepted;
  int   lowcnt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, now, act, exp);
    end
  endtask

  task automatic model_reset();
    now       = 0;
    free_from = 0;
    done_cyc  = -1;
    lo        = 1;
    hi        = 0;
    pidx      = 0;
    accepted  = 1'b0;
  endtask

  function automatic logic in_pulse();
    return (now >= lo) && (now <= hi);
  endfunction

  function automatic line_t exp_lines();
    line_t e;
    for (int b = 1; b <= 8; b++) e[b] = !(in_pulse() && (b == pidx + 1));
    return e;
  endfunction

  // Reference encoder used for the loopback property.
  function automatic logic [3:0] enc8to3(input line_t l);
    for (int i = 0; i < 8; i++) begin
      if (l[i+1] == 1'b0) return {1'b1, i[2:0]};
    end
    return 4'b0000;
  endfunction

  task automatic check_all();
    logic [3:0] lb;
    lb = in_pulse() ? {1'b1, pidx[2:0]} : 4'b0000;
    chk("in_ready", 32'(bus.in_ready), 32'(now >= free_from));
    chk("busy", 32'(busy), 32'(now < free_from));
    chk("done", 32'(done), 32'(now == done_cyc));
    chk("w_n", 32'(w_n), 32'(exp_lines()));
    chk("loopback", 32'(enc8to3(w_n)), 32'(lb));
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    accepted = 1'b0;
    if (now >= free_from && bus.in_valid) begin
      accepted = 1'b1;
      last_acc = now + 1;
      if (bus.code[3]) begin
        lo        = now + 1;
        hi        = now + P;
        pidx      = int'(bus.code[2:0]);
        done_cyc  = now + P + G + 1;
        free_from = now + P + G + 1;
      end else begin
        done_cyc  = now + 1;
        free_from = now + 1;
      end
    end
    now++;
    #1;
    check_all();
  endtask

  task automatic count_low();
    for (int b = 0; b < 8; b++) if (w_n[b+1] === 1'b0) lowcnt[b]++;
  endtask

  initial begin
    int prev_acc;
    int waited;

    bus.in_valid  = 1'b0;
    bus.code      = 4'b0000;
    bus2.in_valid = 1'b0;
    bus2.code     = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset w_n", 32'(w_n), 32'h0FF);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    check_all();

    // Single valid code, index 0.
    bus.code     = 4'b1000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("single w_n T0+1", 32'(w_n), 32'h0FE);
    repeat (3) step();
    chk("single w_n T0+4", 32'(w_n), 32'h0FE);
    step();
    chk("single w_n T0+5", 32'(w_n), 32'h0FF);
    chk("single in_ready T0+5", 32'(bus.in_ready), 32'd0);
    step();
    chk("single in_ready T0+6", 32'(bus.in_ready), 32'd0);
    step();
    chk("single done T0+7", 32'(done), 32'd1);
    chk("single in_ready T0+7", 32'(bus.in_ready), 32'd1);
    step();
    chk("single done T0+8", 32'(done), 32'd0);

    // Null codes back to back.
    bus.code     = 4'b0000;
    bus.in_valid = 1'b1;
    repeat (3) begin
      step();
      chk("null done", 32'(done), 32'd1);
      chk("null w_n", 32'(w_n), 32'h0FF);
      chk("null busy", 32'(busy), 32'd0);
    end
    bus.in_valid = 1'b0;
    step();
    chk("null done after", 32'(done), 32'd0);

    // Index sweep with in_valid held high.
    for (int b = 0; b < 8; b++) lowcnt[b] = 0;
    prev_acc = -1;
    for (int i = 0; i < 8; i++) begin
      bus.code     = {1'b1, 3'(i)};
      bus.in_valid = 1'b1;
      waited       = 0;
      do begin
        step();
        count_low();
        waited++;
      end while (!accepted && waited < 20);
      chk("sweep accept", 32'(accepted), 32'd1);
      if (prev_acc >= 0) chk("sweep spacing", 32'(last_acc - prev_acc), 32'd7);
      prev_acc = last_acc;
    end
    bus.in_valid = 1'b0;
    repeat (8) begin
      step();
      count_low();
    end
    for (int b = 0; b < 8; b++) chk($sformatf("sweep low cycles line %0d", b + 1),
                                    32'(lowcnt[b]), 32'd4);

    // Code changes while busy must be ignored until the done cycle.
    bus.code     = 4'b1010;
    bus.in_valid = 1'b1;
    step();
    chk("mask w_n first", 32'(w_n), 32'h0FB);
    bus.code = 4'b1110;
    repeat (3) step();
    chk("mask w_n held", 32'(w_n), 32'h0FB);
    repeat (3) step();
    chk("mask done cycle ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("mask w_n second", 32'(w_n), 32'h0BF);
    bus.in_valid = 1'b0;
    repeat (7) step();

    // Asynchronous reset in the middle of a pulse.
    bus.code     = 4'b1111;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("pre-reset w_n", 32'(w_n), 32'h07F);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset w_n", 32'(w_n), 32'h0FF);
    chk("async reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all();
    repeat (8) step();

    // PULSE_CYCLES=1, GAP_CYCLES=0 instance.
    bus2.code     = 4'b1101;
    bus2.in_valid = 1'b1;
    step();
    chk("p1g0 w_n T0+1", 32'(w_n2), 32'h0DF);
    chk("p1g0 busy T0+1", 32'(busy2), 32'd1);
    chk("p1g0 ready T0+1", 32'(bus2.in_ready), 32'd0);
    chk("p1g0 done T0+1", 32'(done2), 32'd0);
    step();
    chk("p1g0 w_n T0+2", 32'(w_n2), 32'h0FF);
    chk("p1g0 done T0+2", 32'(done2), 32'd1);
    chk("p1g0 ready T0+2", 32'(bus2.in_ready), 32'd1);
    step();
    chk("p1g0 reaccept w_n", 32'(w_n2), 32'h0DF);
    bus2.in_valid = 1'b0;
    step();
    chk("p1g0 second done", 32'(done2), 32'd1);
    step();
    chk("p1g0 idle w_n", 32'(w_n2), 32'h0FF);

    // Randomized traffic against the model.
    repeat (1500) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.code     = 4'($urandom_range(0, 15));
      step();
    end
    bus.in_valid = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
